// File: rtl/alu_acc_pkg.sv
// alu_acc_pkg: shared types and alu select encodings for the accumulator sequencer
// ALU_ACC_SEQ_CARRY_CHAIN_EN enables ADD-with-carry / SUB-with-borrow via CC_EN
package alu_acc_pkg;
    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_MUL  = 3'd6,
        OP_CLR  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic x;
        logic y;
        logic z;
        logic w;
        logic ci;
    } alu_sel_t;

    localparam alu_sel_t SEL_ADD  = 5'b01000;
    localparam alu_sel_t SEL_SUB  = 5'b11001;
    localparam alu_sel_t SEL_AND  = 5'b00100;
    localparam alu_sel_t SEL_OR   = 5'b00110;
    localparam alu_sel_t SEL_XOR  = 5'b00000;
    localparam alu_sel_t SEL_IDLE = 5'b00000;

`ifdef ALU_ACC_SEQ_CARRY_CHAIN_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif
endpackage

// File: rtl/alu_acc_decode.sv
// alu_acc_decode: maps a command to alu select lines; ci follows flag_c when ALU_ACC_SEQ_CARRY_CHAIN_EN is set
module alu_acc_decode
    import alu_acc_pkg::*;
(
    input  op_t      i_op,
    input  logic     i_flag_c,
    output alu_sel_t o_sel
);
    alu_sel_t w_base;
    logic     w_arith;

    // MUL reuses the plain ADD select so its partial sums never see a carry-in
    assign w_base = (i_op == OP_ADD || i_op == OP_MUL) ? SEL_ADD :
                    (i_op == OP_SUB) ? SEL_SUB :
                    (i_op == OP_AND) ? SEL_AND :
                    (i_op == OP_OR)  ? SEL_OR  :
                    (i_op == OP_XOR) ? SEL_XOR : SEL_IDLE;
    assign w_arith = (i_op == OP_ADD) || (i_op == OP_SUB);

    always_comb begin
        o_sel    = w_base;
        o_sel.ci = (CC_EN && w_arith) ? i_flag_c : w_base.ci;
    end
endmodule

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: accumulator sequencer driving an external alu, with shift-and-add multiply
// Optional carry chain for ADD/SUB/CLR under ALU_ACC_SEQ_CARRY_CHAIN_EN
module alu_acc_seq
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             flag_c,
    output logic             flag_z,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             w,
    output logic             ci,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] g
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    op_t              r_op;
    alu_sel_t         r_sel;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_flag_c;
    logic             r_res_valid;
    logic             r_cmd_ready;
    op_t              w_op;
    alu_sel_t         w_sel;
    logic             w_last;
    logic             w_unused;

    assign w_op     = op_t'(cmd_op);
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_unused = ^c;

    alu_acc_decode u_dec (
        .i_op    (w_op),
        .i_flag_c(r_flag_c),
        .o_sel   (w_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LOAD;
            r_sel       <= SEL_IDLE;
            r_acc       <= '0;
            r_b         <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_flag_c    <= 1'b0;
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: if (cmd_valid) begin
                    r_op        <= w_op;
                    r_b         <= cmd_data;
                    r_sel       <= w_sel;
                    r_cmd_ready <= 1'b0;
                    if (w_op == OP_LOAD || w_op == OP_CLR) begin
                        r_acc       <= (w_op == OP_LOAD) ? cmd_data : '0;
                        r_flag_c    <= (w_op == OP_CLR) && CC_EN && cmd_data[0];
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_op == OP_MUL) begin
                        r_mplier <= r_acc;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_MUL;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_acc       <= g;
                    r_flag_c    <= (r_op == OP_ADD || r_op == OP_SUB) ? c[WIDTH-1] : r_flag_c;
                    r_sel       <= SEL_IDLE;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_MUL: begin
                    // b walks through mcand<<cnt, so shifting it each step keeps it aligned with cnt
                    if (r_mplier[r_cnt]) begin
                        r_acc    <= g;
                        r_flag_c <= r_flag_c | c[WIDTH-1];
                    end
                    r_b   <= r_b << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sel       <= SEL_IDLE;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: if (res_ready) begin
                    r_res_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready         = r_cmd_ready;
    assign res_valid         = r_res_valid;
    assign res_data          = r_acc;
    assign flag_c            = r_flag_c;
    assign flag_z            = r_acc == '0;
    assign {x, y, z, w, ci}  = r_sel;
    assign a                 = r_acc;
    assign b                 = r_b;
endmodule

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq: directed self-checking bench for alu_acc_seq with a behavioural alu attached
module tb_alu_acc_seq;
    import alu_acc_pkg::*;

`ifdef ALU_ACC_SEQ_CARRY_CHAIN_EN
    localparam bit CC = 1'b1;
`else
    localparam bit CC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       flag_c, flag_z;
    logic       x, y, z, w, ci;
    logic [3:0] a, b, c, g;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;
    logic [4:0] sel0;
    logic [3:0] rd;
    logic       fc, fz;

    always #5 clk = ~clk;

    alu_acc_seq #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .flag_c(flag_c), .flag_z(flag_z),
        .x(x), .y(y), .z(z), .w(w), .ci(ci),
        .a(a), .b(b), .c(c), .g(g)
    );

    // Behavioural alu: x inverts b, y selects the adder, {z,w} picks the logic op
    logic [3:0] bb, t;
    logic [4:0] s;
    always_comb begin
        bb = x ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {4'b0, ci};
        t  = a ^ bb ^ s[3:0];
        if (y) begin
            g = s[3:0];
            c = {s[4], t[3:1]};
        end else begin
            g = z ? (w ? (a | b) : (a & b)) : (a ^ b);
            c = 4'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [3:0] data);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_op = op;
        cmd_data = data;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        sel0 = {x, y, z, w, ci};
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = res_data;
        fc = flag_c;
        fz = flag_z;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_data", res_data, 0);
        chk("rst_flag_c", flag_c, 0);
        chk("rst_flag_z", flag_z, 1);
        chk("rst_b", b, 0);
        chk("rst_sel", {x, y, z, w, ci}, 5'b00000);
        reset = 1'b0;
        @(posedge clk); #1;

        cmd(OP_LOAD, 4'b0101);
        chk("load_lat", lat, 1);
        chk("load_data", rd, 4'b0101);
        chk("load_c", fc, 0);
        chk("load_z", fz, 0);

        cmd(OP_LOAD, 4'b1100);
        cmd(OP_ADD, 4'b1010);
        chk("add_lat", lat, 2);
        chk("add_sel", sel0, 5'b01000);
        chk("add_data", rd, 4'b0110);
        chk("add_c", fc, 1);

        cmd(OP_CLR, 4'b0001);
        chk("clr_data", rd, 4'b0000);
        chk("clr_z", fz, 1);
        chk("clr_c", fc, CC);

        cmd(OP_SUB, 4'b0001);
        chk("sub_lat", lat, 2);
        chk("sub_sel", sel0, 5'b11001);
        chk("sub_data", rd, 4'b1111);
        chk("sub_c", fc, 0);

        cmd(OP_AND, 4'b1010);
        chk("and_data", rd, 4'b1010);
        chk("and_c", fc, 0);
        cmd(OP_OR, 4'b0101);
        chk("or_data", rd, 4'b1111);
        cmd(OP_XOR, 4'b1111);
        chk("xor_data", rd, 4'b0000);
        chk("xor_z", fz, 1);

        cmd(OP_LOAD, 4'b0011);
        cmd(OP_MUL, 4'b0101);
        chk("mul1_lat", lat, 5);
        chk("mul1_data", rd, 4'b1111);
        chk("mul1_c", fc, 0);
        cmd(OP_LOAD, 4'b0110);
        cmd(OP_MUL, 4'b0011);
        chk("mul2_lat", lat, 5);
        chk("mul2_data", rd, 4'b0010);
        chk("mul2_c", fc, 1);

        cmd_op = OP_LOAD;
        cmd_data = 4'b1001;
        cmd_valid = 1'b1;
        res_ready = 1'b0;
        @(posedge clk); #1;
        cmd_data = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_data", res_data, 4'b1001);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_clear", res_valid, 0);
        chk("bp_ready_back", cmd_ready, 1);
        chk("bp_no_second", res_data, 4'b1001);

        cmd(OP_CLR, 4'b0001);
        cmd(OP_OR, 4'b1111);
        cmd(OP_ADD, 4'b0000);
        chk("cc_add_data", rd, CC ? 4'b0000 : 4'b1111);
        chk("cc_add_c", fc, CC);

        cmd(OP_LOAD, 4'b0111);
        cmd_op = OP_MUL;
        cmd_data = 4'b0011;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_mul_sel", {x, y, z, w, ci}, 5'b01000);
        #2 reset = 1'b1;
        #1;
        chk("mr_res_valid", res_valid, 0);
        chk("mr_cmd_ready", cmd_ready, 1);
        chk("mr_res_data", res_data, 0);
        chk("mr_flag_c", flag_c, 0);
        chk("mr_flag_z", flag_z, 1);
        chk("mr_b", b, 0);
        chk("mr_sel", {x, y, z, w, ci}, 5'b00000);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        chk("mr_no_result", seen, 0);
        chk("mr_idle_ready", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
Accumulator sequencer placed directly upstream of the combinational alu. It accepts commands over a valid/ready handshake and drives the alu select lines (x, y, z, w, ci) and operands (a, b). It latches the alu result (g, c) back into an accumulator register. It also performs a multi-cycle shift-and-add multiply by iterating the alu, and returns results plus carry/zero flags over a second valid/ready handshake.

Parameters:
WIDTH, 4, data width; must equal the WIDTH of the attached alu.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  command code (package enum op_t)
cmd_data  input  WIDTH  operand for the command
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  accumulator value after the command
flag_c  output  1  carry flag
flag_z  output  1  zero flag (res_data == 0)
x, y, z, w  output  1 each  alu operation select
ci  output  1  alu carry-in
a  output  WIDTH  alu operand a (always the accumulator)
b  output  WIDTH  alu operand b
c  input  WIDTH  alu carry vector; c[WIDTH-1] is carry-out
g  input  WIDTH  alu result

Behaviour:
- op_t values: LOAD=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, MUL=6, CLR=7.
- alu select {x,y,z,w,ci}:
  - ADD = 0100,ci=0
  - SUB = 1100,ci=1
  - AND = 0010,ci=0
  - OR = 0011,ci=0
  - XOR = 0000,ci=0
  - idle = 0000,ci=0
- All outputs are registered; a = acc.
- Reset values: acc=0, flag_c=0, flag_z=1, res_valid=0, cmd_ready=1, b=0, select=idle, state=IDLE.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op and cmd_data into b.
  - LOAD/CLR: write acc directly (cmd_data / 0), flag_c=0, go to DONE.
  - ADD/SUB/AND/OR/XOR: drive select, go to EXEC.
  - MUL: mcand<=cmd_data, mplier<=acc, acc<=0, cnt<=0, go to MUL.
- EXEC (1 cycle): acc<=g. flag_c<=c[WIDTH-1] for ADD/SUB; flag_c is unchanged for logic ops. Go to DONE.
- Latencies from the accept edge to res_valid: 1 cycle for LOAD/CLR, 2 cycles for ALU ops, WIDTH+1 cycles for MUL.
- MUL runs WIDTH cycles; cnt goes 0..WIDTH-1. Each cycle:
  - ADD select is driven with b=mcand<<cnt (truncated to WIDTH).
  - If mplier[cnt]=1: acc<=g, and flag_c<=flag_c|c[WIDTH-1] (sticky overflow of the low-half product).
  - On cnt==WIDTH-1, go to DONE.
- DONE:
  - res_valid=1, cmd_ready=0.
  - res_data=acc; flag_z is computed combinationally from acc.
  - Hold until res_ready, then return to IDLE. res_valid clears on the cycle after the handshake.
- Command handshake: cmd_ready is high only in IDLE, so no command is accepted while busy or while a result is pending. Back-to-back commands therefore need at least one IDLE cycle.
- Wrap-around: all arithmetic is modulo 2^WIDTH. SUB 0-1 gives acc=all ones, flag_c=0 (borrow). MUL keeps only the low WIDTH bits.
- Reset asserted mid-operation: immediate return to reset values. Any pending result is discarded and no res_valid is emitted.
- An undefined cmd_op cannot occur; all 8 codes are defined.

Optional Feature:
- Macro: ALU_ACC_SEQ_CARRY_CHAIN_EN.
- When defined, ADD and SUB drive ci=flag_c (ADD-with-carry, SUB-with-borrow-in, where flag_c=1 means no borrow). This enables multi-word arithmetic.
- CLR then sets flag_c=1 when cmd_data[0]=1, otherwise flag_c=0.
- When undefined, ci is fixed per the select encoding above and CLR always clears flag_c.

Decomposition:
- Package alu_acc_pkg: op_t enum, state_t enum, alu_sel_t packed struct {x,y,z,w,ci}, and localparams SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_XOR, SEL_IDLE.
- One sub-module, alu_acc_decode: combinational op_t -> alu_sel_t, handling the macro-dependent ci.
- The alu itself is instantiated only in the testbench, never inside this block.

Test Plan:
- Reset, then LOAD 0101 with res_ready=1 -> res_valid one cycle after accept; res_data=0101, flag_c=0, flag_z=0.
- acc=1100: ADD 1010 -> res_data=0110, flag_c=1, 2-cycle latency; select observed as 0100.
- acc=0000: SUB 0001 -> res_data=1111, flag_c=0. Then AND 1010 -> 1010; OR 0101 -> 1111; XOR 1111 -> 0000 with flag_z=1.
- acc=0011, MUL 0101 -> res_data=1111, flag_c=0, res_valid exactly WIDTH+1 cycles after accept. acc=0110, MUL 0011 -> 0010, flag_c=1.
- Hold res_ready=0 for 5 cycles with cmd_valid=1 -> cmd_ready stays 0, res_data stable, no second command accepted.
- Assert reset during the MUL state -> all outputs return to reset values, no res_valid. With ALU_ACC_SEQ_CARRY_CHAIN_EN: acc=1111, flag_c=1, ADD 0000 -> 0000, flag_c=1.
